// File: rtl/leds_pkg.sv
// Shared constants and FSM state encoding for the LED memory checker.
package leds_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 32;
   localparam int ERR_W_DEF  = 16;

   // Plain vector encoding keeps the state register easy to probe from older tools.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_WRITE = 3'd1;
   localparam state_t ST_READ  = 3'd2;
   localparam state_t ST_RWAIT = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/leds_mem_checker_if.sv
// Avalon-MM bus between the checker (master) and the memory under test (slave).
interface leds_mem_checker_if
   import leds_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [ADDR_W-1:0]   avm_address;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic                avm_read;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_waitrequest;
   logic                avm_readdatavalid;

   modport master (
      output avm_address, avm_byteenable, avm_write, avm_writedata, avm_read,
      input  avm_readdata, avm_waitrequest, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_byteenable, avm_write, avm_writedata, avm_read,
      output avm_readdata, avm_waitrequest, avm_readdatavalid
   );

endinterface

// File: rtl/leds_pattern_gen.sv
// Word index counter plus the seed+index test pattern derived from it.
module leds_pattern_gen #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic [DATA_W-1:0] seed_i,
   output logic [ADDR_W:0]   idx_o,
   output logic [DATA_W-1:0] pattern_o
);

   logic [ADDR_W:0] idx_q;
   logic [ADDR_W:0] idx_d;

   // Load (restart at word 0) wins over increment.
   always_comb begin
      idx_d = idx_q;
      if (load_i) begin
         idx_d = '0;
      end else if (inc_i) begin
         idx_d = idx_q + (ADDR_W+1)'(1);
      end
   end

   // Index register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx_o     = idx_q;
   assign pattern_o = seed_i + DATA_W'(idx_q);

endmodule

// File: rtl/leds_mem_checker.sv
// Writes seed+i to a block of words, reads it back and counts mismatches.
module leds_mem_checker
   import leds_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ERR_W  = ERR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   length,
   input  logic [DATA_W-1:0] seed,
   leds_mem_checker_if.master avm,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   length_q;
   logic [DATA_W-1:0] seed_q;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic              pass_q, pass_d;
   logic              aborted_q, aborted_d;

   logic              accept;
   logic              pg_load;
   logic              pg_inc;
   logic [ADDR_W:0]   pg_idx;
   logic [DATA_W-1:0] pattern;
   logic [ADDR_W-1:0] cur_addr;
   logic              last_idx;
   logic              mismatch;

   leds_pattern_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_pattern (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (pg_load),
      .inc_i     (pg_inc),
      .seed_i    (seed_q),
      .idx_o     (pg_idx),
      .pattern_o (pattern)
   );

   // Address wraps modulo 2^ADDR_W because the sum is truncated to ADDR_W bits.
   assign cur_addr = base_q + pg_idx[ADDR_W-1:0];
   assign last_idx = (pg_idx == length_q - (ADDR_W+1)'(1));
   assign mismatch = (avm.avm_readdata != pattern);

   // Next-state logic; an abort seen while a command is stalled is remembered
   // so the command is completed before the run ends.
   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      first_d   = first_q;
      pass_d    = pass_q;
      aborted_d = aborted_q;
      accept    = 1'b0;
      pg_load   = 1'b0;
      pg_inc    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               pg_load   = 1'b1;
               err_d     = '0;
               first_d   = '0;
               pass_d    = 1'b0;
               aborted_d = 1'b0;
               state_d   = (length == '0) ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (abort) aborted_d = 1'b1;
            if (!avm.avm_waitrequest) begin
               if (abort || aborted_q) begin
                  state_d = ST_DONE;
               end else if (last_idx) begin
                  state_d = ST_READ;
                  pg_load = 1'b1;
               end else begin
                  pg_inc = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (abort) aborted_d = 1'b1;
            // An accepted read always waits for its data, even when aborting.
            if (!avm.avm_waitrequest) state_d = ST_RWAIT;
         end
         ST_RWAIT: begin
            if (abort) aborted_d = 1'b1;
            if (avm.avm_readdatavalid) begin
               if (abort || aborted_q) begin
                  state_d = ST_DONE;
               end else begin
                  if (mismatch) begin
                     if (err_q != '1) err_d = err_q + ERR_W'(1);
                     if (err_q == '0) first_d = cur_addr;
                  end
                  if (last_idx) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_READ;
                     pg_inc  = 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            pass_d  = !aborted_q && (err_q == '0);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         err_q     <= '0;
         first_q   <= '0;
         pass_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         first_q   <= first_d;
         pass_q    <= pass_d;
         aborted_q <= aborted_d;
      end
   end

   // Run parameters captured when a run is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q   <= '0;
         length_q <= '0;
         seed_q   <= '0;
      end else if (accept) begin
         base_q   <= base;
         length_q <= length;
         seed_q   <= seed;
      end
   end

   assign avm.avm_write      = (state_q == ST_WRITE);
   assign avm.avm_read       = (state_q == ST_READ);
   assign avm.avm_address    = cur_addr;
   assign avm.avm_writedata  = pattern;
   assign avm.avm_byteenable = ((state_q == ST_WRITE) || (state_q == ST_READ)) ? '1 : '0;

   assign busy           = (state_q != ST_IDLE);
   assign done           = (state_q == ST_DONE);
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = first_q;

endmodule

// File: tb/tb_leds_mem_checker.sv
// Directed bench for leds_mem_checker with a configurable stalling memory slave.
module tb_leds_mem_checker;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int EW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] seed = '0;
   logic          busy, done, pass;
   logic [EW-1:0] err_count;
   logic [AW-1:0] first_err_addr;

   int checks = 0;
   int failures = 0;

   leds_mem_checker_if #(.ADDR_W(AW), .DATA_W(DW)) avm_if ();

   leds_mem_checker #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(EW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .abort          (abort),
      .base           (base),
      .length         (length),
      .seed           (seed),
      .avm            (avm_if),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   always #5 clk = ~clk;

   // ---------------- memory slave model ----------------
   int          cfg_wait = 0;
   int          cfg_lat = 1;
   bit          cfg_corrupt = 1'b0;
   int          stall_cnt;
   int          pend_cnt;
   logic [DW-1:0] pend_data;
   logic        rvalid;
   logic [DW-1:0] rdata;
   logic        waitreq;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] wr_addr_q [$];
   logic [DW-1:0] wr_data_q [$];
   logic [AW-1:0] rd_addr_q [$];
   wire         cmd = avm_if.avm_write || avm_if.avm_read;

   assign waitreq                  = cmd && (stall_cnt != cfg_wait);
   assign avm_if.avm_waitrequest   = waitreq;
   assign avm_if.avm_readdatavalid = rvalid;
   assign avm_if.avm_readdata      = rdata;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= 0;
         pend_cnt  <= 0;
         rvalid    <= 1'b0;
         rdata     <= '0;
      end else begin
         rvalid <= 1'b0;
         if (pend_cnt == 1) begin
            rvalid   <= 1'b1;
            rdata    <= pend_data;
            pend_cnt <= 0;
         end else if (pend_cnt > 1) begin
            pend_cnt <= pend_cnt - 1;
         end
         if (cmd && waitreq) begin
            stall_cnt <= stall_cnt + 1;
         end else if (cmd) begin
            stall_cnt <= 0;
            if (avm_if.avm_write) begin
               mem[avm_if.avm_address] <= avm_if.avm_writedata;
               wr_addr_q.push_back(avm_if.avm_address);
               wr_data_q.push_back(avm_if.avm_writedata);
               $display("txn WR addr=%h data=%h", avm_if.avm_address, avm_if.avm_writedata);
            end else begin
               rd_addr_q.push_back(avm_if.avm_address);
               pend_cnt  <= cfg_lat;
               pend_data <= mem[avm_if.avm_address] ^
                  ((cfg_corrupt && (avm_if.avm_address == 14'h0012 || avm_if.avm_address == 14'h0013)) ? 32'h0000_0001 : 32'h0);
               $display("txn RD addr=%h", avm_if.avm_address);
            end
         end
      end
   end

   // ---------------- bus protocol monitor ----------------
   int stall_viol = 0, rw_viol = 0, be_viol = 0, stall_seen = 0, cmd_cycles = 0;
   logic prev_stalled = 1'b0, prev_w = 1'b0, prev_r = 1'b0;
   logic [AW-1:0] prev_a = '0;
   logic [DW-1:0] prev_d = '0;

   always @(negedge clk) begin
      if (reset_n && prev_stalled &&
          (avm_if.avm_write !== prev_w || avm_if.avm_read !== prev_r || avm_if.avm_address !== prev_a ||
           (avm_if.avm_write && avm_if.avm_writedata !== prev_d)))
         stall_viol <= stall_viol + 1;
      if (avm_if.avm_write && avm_if.avm_read) rw_viol <= rw_viol + 1;
      if (avm_if.avm_write && avm_if.avm_byteenable !== 4'hF) be_viol <= be_viol + 1;
      if (cmd && waitreq) stall_seen <= stall_seen + 1;
      if (cmd) cmd_cycles <= cmd_cycles + 1;
      prev_stalled <= cmd && waitreq && reset_n;
      prev_w <= avm_if.avm_write;
      prev_r <= avm_if.avm_read;
      prev_a <= avm_if.avm_address;
      prev_d <= avm_if.avm_writedata;
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
   endtask

   task automatic start_run(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] s);
      @(posedge clk); #1;
      base = b; length = l; seed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass: got %b want 0", pass); end
      checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL reset_err: got %h want 0", err_count); end
      checks++; if (first_err_addr !== 14'h0) begin failures++; $display("FAIL reset_first: got %h want 0", first_err_addr); end
      checks++; if (avm_if.avm_write !== 1'b0 || avm_if.avm_read !== 1'b0) begin failures++; $display("FAIL reset_cmd: got w=%b r=%b want 0 0", avm_if.avm_write, avm_if.avm_read); end
      checks++; if (avm_if.avm_address !== 14'h0 || avm_if.avm_writedata !== 32'h0 || avm_if.avm_byteenable !== 4'h0) begin
         failures++; $display("FAIL reset_bus: got a=%h d=%h be=%h want 0 0 0", avm_if.avm_address, avm_if.avm_writedata, avm_if.avm_byteenable); end
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      bit seen;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cfg_wait = 0; cfg_lat = 1; cfg_corrupt = 1'b0;
      clear_logs();
      start_run(14'h0010, 15'd4, 32'hA5A5_0000);
      wait_done(200, seen);
      @(negedge clk); #1;
      checks++; if (!seen) begin failures++; $display("FAIL basic_done: got no pulse want pulse"); end
      checks++; if (wr_addr_q.size() != 4 || rd_addr_q.size() != 4) begin failures++; $display("FAIL basic_count: got wr=%0d rd=%0d want 4 4", wr_addr_q.size(), rd_addr_q.size()); end
      for (int k = 0; k < 4; k++) begin
         ea = AW'(32'h10 + k);
         ed = 32'hA5A5_0000 + DW'(k);
         checks++; if (wr_addr_q[k] !== ea || wr_data_q[k] !== ed) begin failures++; $display("FAIL basic_wr%0d: got %h/%h want %h/%h", k, wr_addr_q[k], wr_data_q[k], ea, ed); end
         checks++; if (rd_addr_q[k] !== ea) begin failures++; $display("FAIL basic_rd%0d: got %h want %h", k, rd_addr_q[k], ea); end
      end
      checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin failures++; $display("FAIL basic_result: got pass=%b err=%h want 1 0", pass, err_count); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_idle: got busy=%b done=%b want 0 0", busy, done); end
      checks++; if (be_viol != 0 || rw_viol != 0) begin failures++; $display("FAIL basic_proto: got be_viol=%0d rw_viol=%0d want 0 0", be_viol, rw_viol); end
   endtask

   task automatic test_stall();
      bit seen;
      int s0, v0;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cfg_wait = 3; cfg_lat = 2; cfg_corrupt = 1'b0;
      clear_logs();
      s0 = stall_seen; v0 = stall_viol;
      start_run(14'h0010, 15'd4, 32'hA5A5_0000);
      wait_done(400, seen);
      @(negedge clk); #1;
      checks++; if (!seen) begin failures++; $display("FAIL stall_done: got no pulse want pulse"); end
      checks++; if (stall_seen - s0 != 24) begin failures++; $display("FAIL stall_cycles: got %0d want 24", stall_seen - s0); end
      checks++; if (stall_viol != v0) begin failures++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol - v0); end
      checks++; if (wr_addr_q.size() != 4 || rd_addr_q.size() != 4) begin failures++; $display("FAIL stall_count: got wr=%0d rd=%0d want 4 4", wr_addr_q.size(), rd_addr_q.size()); end
      for (int k = 0; k < 4; k++) begin
         ea = AW'(32'h10 + k);
         ed = 32'hA5A5_0000 + DW'(k);
         checks++; if (wr_addr_q[k] !== ea || wr_data_q[k] !== ed || rd_addr_q[k] !== ea) begin
            failures++; $display("FAIL stall_txn%0d: got %h/%h/%h want %h/%h/%h", k, wr_addr_q[k], wr_data_q[k], rd_addr_q[k], ea, ed, ea); end
      end
      checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin failures++; $display("FAIL stall_result: got pass=%b err=%h want 1 0", pass, err_count); end
   endtask

   task automatic test_wrap();
      bit seen;
      logic [AW-1:0] exp_a [4];
      exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
      cfg_wait = 0; cfg_lat = 1; cfg_corrupt = 1'b0;
      clear_logs();
      start_run(14'h3FFE, 15'd4, 32'h0000_0100);
      wait_done(200, seen);
      @(negedge clk); #1;
      checks++; if (!seen) begin failures++; $display("FAIL wrap_done: got no pulse want pulse"); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (wr_addr_q[k] !== exp_a[k] || rd_addr_q[k] !== exp_a[k]) begin
            failures++; $display("FAIL wrap_addr%0d: got wr=%h rd=%h want %h", k, wr_addr_q[k], rd_addr_q[k], exp_a[k]); end
      end
      checks++; if (pass !== 1'b1) begin failures++; $display("FAIL wrap_pass: got %b want 1", pass); end
   endtask

   task automatic test_corrupt();
      bit seen;
      cfg_wait = 0; cfg_lat = 1; cfg_corrupt = 1'b1;
      clear_logs();
      start_run(14'h0010, 15'd4, 32'hA5A5_0000);
      wait_done(200, seen);
      @(negedge clk); #1;
      checks++; if (!seen) begin failures++; $display("FAIL corrupt_done: got no pulse want pulse"); end
      checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL corrupt_err: got %0d want 2", err_count); end
      checks++; if (first_err_addr !== 14'h0012) begin failures++; $display("FAIL corrupt_first: got %h want 0012", first_err_addr); end
      checks++; if (pass !== 1'b0) begin failures++; $display("FAIL corrupt_pass: got %b want 0", pass); end
      repeat (5) @(negedge clk);
      #1;
      checks++; if (err_count !== 16'd2 || first_err_addr !== 14'h0012) begin failures++; $display("FAIL corrupt_hold: got err=%0d first=%h want 2 0012", err_count, first_err_addr); end
      cfg_corrupt = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit seen;
      cfg_wait = 0; cfg_lat = 1; cfg_corrupt = 1'b0;
      clear_logs();
      start_run(14'h0040, 15'd3, 32'h1234_5678);
      checks++; if (err_count !== 16'h0 || first_err_addr !== 14'h0 || busy !== 1'b1) begin
         failures++; $display("FAIL b2b_clear: got err=%h first=%h busy=%b want 0 0 1", err_count, first_err_addr, busy); end
      wait_done(200, seen);
      @(negedge clk); #1;
      checks++; if (!seen || pass !== 1'b1 || rd_addr_q.size() != 3) begin
         failures++; $display("FAIL b2b_result: got seen=%b pass=%b reads=%0d want 1 1 3", seen, pass, rd_addr_q.size()); end
   endtask

   task automatic test_abort_write();
      bit seen;
      cfg_wait = 3; cfg_lat = 1; cfg_corrupt = 1'b0;
      clear_logs();
      start_run(14'h0100, 15'd4, 32'h0000_0AA0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done(200, seen);
      @(negedge clk); #1;
      checks++; if (!seen) begin failures++; $display("FAIL abw_done: got no pulse want pulse"); end
      checks++; if (wr_addr_q.size() != 1 || rd_addr_q.size() != 0) begin failures++; $display("FAIL abw_count: got wr=%0d rd=%0d want 1 0", wr_addr_q.size(), rd_addr_q.size()); end
      checks++; if (wr_addr_q[0] !== 14'h0100) begin failures++; $display("FAIL abw_addr: got %h want 0100", wr_addr_q[0]); end
      checks++; if (pass !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abw_result: got pass=%b busy=%b want 0 0", pass, busy); end
   endtask

   task automatic test_abort_rwait();
      bit got, seen;
      int c0, cyc, rv_cyc, dn_cyc;
      cfg_wait = 0; cfg_lat = 5; cfg_corrupt = 1'b0;
      clear_logs();
      got = 1'b0; seen = 1'b0; rv_cyc = -1; dn_cyc = -1;
      start_run(14'h0020, 15'd4, 32'h0000_0001);
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (rd_addr_q.size() >= 1) begin got = 1'b1; break; end
      end
      checks++; if (!got) begin failures++; $display("FAIL abr_read: got no read accepted want one"); end
      c0 = cmd_cycles;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      cyc = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         cyc++;
         if (avm_if.avm_readdatavalid && rv_cyc < 0) rv_cyc = cyc;
         if (done) begin dn_cyc = cyc; seen = 1'b1; break; end
      end
      @(negedge clk); #1;
      checks++; if (!seen || rv_cyc < 0 || dn_cyc != rv_cyc + 1) begin
         failures++; $display("FAIL abr_timing: got valid@%0d done@%0d want done one cycle after valid", rv_cyc, dn_cyc); end
      checks++; if (cmd_cycles != c0 || rd_addr_q.size() != 1) begin failures++; $display("FAIL abr_nocmd: got cmd_cycles+%0d reads=%0d want +0 1", cmd_cycles - c0, rd_addr_q.size()); end
      checks++; if (pass !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abr_result: got pass=%b busy=%b want 0 0", pass, busy); end
   endtask

   task automatic test_zero_len_reset();
      bit seen;
      int c0;
      cfg_wait = 0; cfg_lat = 1; cfg_corrupt = 1'b0;
      clear_logs();
      c0 = cmd_cycles;
      start_run(14'h0200, 15'd0, 32'hDEAD_BEEF);
      wait_done(20, seen);
      @(negedge clk); #1;
      checks++; if (!seen) begin failures++; $display("FAIL zero_done: got no pulse want pulse"); end
      checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin failures++; $display("FAIL zero_result: got pass=%b err=%h want 1 0", pass, err_count); end
      checks++; if (cmd_cycles != c0) begin failures++; $display("FAIL zero_bus: got %0d command cycles want 0", cmd_cycles - c0); end
      cfg_wait = 3;
      clear_logs();
      start_run(14'h0000, 15'd8, 32'h0000_0055);
      #1;
      checks++; if (avm_if.avm_write !== 1'b1) begin failures++; $display("FAIL rst_pre: got write=%b want 1", avm_if.avm_write); end
      reset_n = 1'b0;
      #1;
      checks++; if (avm_if.avm_write !== 1'b0 || avm_if.avm_read !== 1'b0) begin failures++; $display("FAIL rst_async: got w=%b r=%b want 0 0", avm_if.avm_write, avm_if.avm_read); end
      checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'h0 || first_err_addr !== 14'h0) begin
         failures++; $display("FAIL rst_status: got busy=%b done=%b pass=%b err=%h first=%h want all 0", busy, done, pass, err_count, first_err_addr); end
      checks++; if (avm_if.avm_address !== 14'h0 || avm_if.avm_writedata !== 32'h0 || avm_if.avm_byteenable !== 4'h0) begin
         failures++; $display("FAIL rst_bus: got a=%h d=%h be=%h want 0 0 0", avm_if.avm_address, avm_if.avm_writedata, avm_if.avm_byteenable); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      c0 = cmd_cycles;
      repeat (10) @(negedge clk);
      #1;
      checks++; if (cmd_cycles != c0 || wr_addr_q.size() != 0 || busy !== 1'b0) begin
         failures++; $display("FAIL rst_quiet: got cmd+%0d writes=%0d busy=%b want 0 0 0", cmd_cycles - c0, wr_addr_q.size(), busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_corrupt();
      test_back_to_back();
      test_abort_write();
      test_abort_rwait();
      test_zero_len_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/leds_mem_checker.md
LEDS_MEM_CHECKER -- requirements
Module: leds_mem_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, word-address width of the target memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter ERR_W, default 16, error-counter width.
REQ-004 SHALL have port clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports start  in  1 (pulse, begin run); abort  in  1 (pulse, stop run).
REQ-007 SHALL have ports base  in  ADDR_W (first word address); length  in  ADDR_W+1 (word count, 0..2^ADDR_W); seed  in  DATA_W (pattern seed).
REQ-008 SHALL have Avalon-MM master ports avm_address  out  ADDR_W; avm_byteenable  out  DATA_W/8; avm_write  out  1; avm_writedata  out  DATA_W; avm_read  out  1.
REQ-009 SHALL have Avalon-MM master inputs avm_readdata  in  DATA_W; avm_waitrequest  in  1; avm_readdatavalid  in  1.
REQ-010 SHALL have status ports busy  out  1; done  out  1 (one-cycle pulse); pass  out  1; err_count  out  ERR_W; first_err_addr  out  ADDR_W.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, READ, RWAIT, DONE.
REQ-012 SHALL sample base, length and seed into internal registers on start in IDLE; start outside IDLE is ignored.
REQ-013 SHALL, on start with length=0, go IDLE->DONE, leaving err_count=0 and setting pass=1.
REQ-014 SHALL, in WRITE, drive avm_write=1, avm_address=base+i, avm_writedata=seed+i (mod 2^DATA_W), byteenable all ones, for i=0..length-1.
REQ-015 SHALL hold address, data and avm_write stable while avm_waitrequest=1; advance i only on the cycle avm_write=1 and avm_waitrequest=0.
REQ-016 SHALL compute addresses modulo 2^ADDR_W (base+i wraps past the top word to 0).
REQ-017 SHALL, after the last accepted write, reset i to 0 and enter READ with no idle cycle.
REQ-018 SHALL, in READ, drive avm_read=1 at base+i, hold while waitrequest=1, and enter RWAIT on acceptance; at most one read is outstanding.
REQ-019 SHALL, in RWAIT, keep avm_read=0 and wait for avm_readdatavalid, then compare avm_readdata with seed+i.
REQ-020 SHALL, on mismatch, increment err_count, saturating at all-ones, and capture first_err_addr only on the first mismatch of the run.
REQ-021 SHALL, after the compare for i=length-1, enter DONE; otherwise return to READ with i+1.
REQ-022 SHALL, in DONE, assert done for exactly one cycle, set pass=(err_count==0), and return to IDLE.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL, on abort in WRITE or READ, finish any transfer already presented with waitrequest=1 (no command withdrawn), then go to DONE with pass=0.
REQ-025 SHALL, on abort in RWAIT, wait for readdatavalid, discard the data, then go to DONE with pass=0.
REQ-026 SHALL give abort priority over the normal transition when both occur in the same cycle.
REQ-027 SHALL clear err_count, first_err_addr and pass when a new run is accepted; these hold their values between runs.
REQ-028 SHALL never assert avm_read and avm_write in the same cycle.

Reset
REQ-029 SHALL, while reset_n=0, force state=IDLE, i=0, avm_read=0, avm_write=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
REQ-030 SHALL, on reset mid-run, abandon the run immediately with no further bus commands; a late readdatavalid after reset is ignored.

Structure
REQ-031 SHALL place the FSM state enumeration and the default ADDR_W/DATA_W/ERR_W constants in a shared package leds_pkg.
REQ-032 SHALL factor the pattern generator (seed+i, registered index counter with load/increment) into one sub-module leds_pattern_gen; all else is flat.

Verification
REQ-033 Zero-wait slave, base=0x0010, length=4, seed=0xA5A50000 -> writes 0xA5A50000..0xA5A50003 to 0x0010..0x0013, four reads, done pulse, pass=1, err_count=0.
REQ-034 Slave holds waitrequest=1 for 3 cycles on every command, read latency 2 -> command signals stable during stalls; outcome identical to REQ-033.
REQ-035 base=0x3FFE, length=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 for both writes and reads.
REQ-036 Slave corrupts readdata at 0x0012 and 0x0013 -> err_count=2, first_err_addr=0x0012, pass=0.
REQ-037 abort asserted while in RWAIT with readdatavalid delayed 5 cycles -> no new command is issued; done is pulsed 1 cycle after readdatavalid; pass=0; busy drops.
REQ-038 length=0 start, then reset_n pulsed low mid-WRITE of a length=8 run -> first: done pulse with pass=1 and no bus activity; second: avm_write drops asynchronously and all outputs are at their reset values.
